// File: rtl/aes_ark_stream.sv
// Streaming AES AddRoundKey: latches one 128-bit round key per block and XORs
// DATA_W-bit state beats against the matching key slice, with valid/ready flow control.
module aes_ark_stream #(
  parameter int DATA_W  = 8,
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [127:0]      key_in,
  input  logic              bypass,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              len_err
);

  localparam int BEATS = 128 / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {KEY_WAIT = 1'b0, STREAM = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [127:0]       r_key;
  logic               r_byp;
  logic               r_len_err;
  logic               w_down_ok;
  logic               w_accept;
  logic               w_cnt_last;
  logic               w_blk_end;
  logic [DATA_W-1:0]  w_res;

  // Beat 0 uses the most significant slice of the key.
  function automatic logic [DATA_W-1:0] key_slice(input logic [127:0] key,
                                                  input logic [CNT_W-1:0] idx);
    logic [127:0] sh;
    sh = key << (int'(idx) * DATA_W);
    return sh[127 -: DATA_W];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= KEY_WAIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = KEY_WAIT;
    end else begin
      case (r_state)
        KEY_WAIT: if (key_valid) w_state_nxt = STREAM;
        STREAM:   if (w_accept && w_blk_end) w_state_nxt = KEY_WAIT;
        default:  w_state_nxt = KEY_WAIT;
      endcase
    end
  end

  always_comb begin
    key_ready = (r_state == KEY_WAIT);
    in_ready  = (r_state == STREAM) && w_down_ok && !clear;
  end

  assign w_accept   = in_valid && in_ready;
  assign w_cnt_last = (r_beat_cnt == LAST_BEAT);
  assign w_blk_end  = w_cnt_last || in_last;
  assign w_res      = in_data ^ (r_byp ? '0 : key_slice(r_key, r_beat_cnt));
  assign len_err    = r_len_err;
  assign busy       = (r_state == STREAM) || out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_key      <= '0;
      r_byp      <= 1'b0;
      r_len_err  <= 1'b0;
    end else if (clear) begin
      r_beat_cnt <= '0;
      r_key      <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= w_accept && (in_last != w_cnt_last);
      if (r_state == KEY_WAIT && key_valid) begin
        r_key <= key_in;
        r_byp <= bypass;
      end
      if (w_accept) r_beat_cnt <= w_blk_end ? '0 : r_beat_cnt + 1'b1;
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic              r_out_valid_p1;
      logic [DATA_W-1:0] r_out_data_p1;
      logic              r_out_last_p1;

      // Output stage p1: single-entry register, holds while downstream stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_valid_p1 <= 1'b0;
          r_out_data_p1  <= '0;
          r_out_last_p1  <= 1'b0;
        end else if (clear) begin
          r_out_valid_p1 <= 1'b0;
        end else if (w_accept) begin
          r_out_valid_p1 <= 1'b1;
          r_out_data_p1  <= w_res;
          r_out_last_p1  <= w_blk_end;
        end else if (out_ready) begin
          r_out_valid_p1 <= 1'b0;
        end
      end

      assign w_down_ok = !r_out_valid_p1 || out_ready;
      assign out_valid = r_out_valid_p1;
      assign out_data  = r_out_data_p1;
      assign out_last  = r_out_last_p1;
    end else begin : g_comb
      assign w_down_ok = out_ready;
      assign out_valid = (r_state == STREAM) && in_valid && !clear;
      assign out_data  = w_res;
      assign out_last  = out_valid && w_blk_end;
    end
  endgenerate

endmodule

// File: tb/tb_aes_ark_stream.sv
// Bench for aes_ark_stream: scoreboarded 8-bit/registered instance plus
// 32-bit combinational and 128-bit registered instances checked directly.
module tb_aes_ark_stream;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ST  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EX1 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] KF  = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] EXF = 128'hffeeddccbbaa99887766554433221100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit registered instance
  logic         clear = 0, key_valid = 0, bypass = 0, in_valid = 0, in_last = 0, out_ready;
  logic [127:0] key_in = '0;
  logic [7:0]   in_data = '0, out_data;
  logic         key_ready, in_ready, out_valid, out_last, busy, len_err;

  aes_ark_stream #(.DATA_W(8), .OUT_REG(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .bypass(bypass), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .len_err(len_err));

  // 32-bit combinational instance
  logic         d2_clear = 0, d2_key_valid = 0, d2_bypass = 0, d2_in_valid = 0, d2_in_last = 0;
  logic         d2_out_ready = 1;
  logic [127:0] d2_key_in = '0;
  logic [31:0]  d2_in_data = '0, d2_out_data;
  logic         d2_key_ready, d2_in_ready, d2_out_valid, d2_out_last, d2_busy, d2_len_err;

  aes_ark_stream #(.DATA_W(32), .OUT_REG(1'b0)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .clear(d2_clear), .key_valid(d2_key_valid),
    .key_ready(d2_key_ready), .key_in(d2_key_in), .bypass(d2_bypass),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
    .in_last(d2_in_last), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .out_data(d2_out_data), .out_last(d2_out_last), .busy(d2_busy), .len_err(d2_len_err));

  // 128-bit registered instance
  logic         d3_clear = 0, d3_key_valid = 0, d3_bypass = 0, d3_in_valid = 0, d3_in_last = 0;
  logic         d3_out_ready = 1;
  logic [127:0] d3_key_in = '0, d3_in_data = '0, d3_out_data;
  logic         d3_key_ready, d3_in_ready, d3_out_valid, d3_out_last, d3_busy, d3_len_err;

  aes_ark_stream #(.DATA_W(128), .OUT_REG(1'b1)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .clear(d3_clear), .key_valid(d3_key_valid),
    .key_ready(d3_key_ready), .key_in(d3_key_in), .bypass(d3_bypass),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_data(d3_in_data),
    .in_last(d3_in_last), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_data(d3_out_data), .out_last(d3_out_last), .busy(d3_busy), .len_err(d3_len_err));

  int n_cmp = 0;
  int n_err = 0;
  int lerr_cnt = 0;
  int mode = 0;
  logic [8:0] sb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Downstream ready: 0 = always ready, 1 = pattern 1,0,0, 2 = never ready
  initial begin
    int pat = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = (pat == 0); pat = (pat + 1) % 3; end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks stall behaviour
  initial begin
    logic       stall_prev = 1'b0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid) begin
          chk("stall_data", out_data, prev_d);
          chk("stall_last", out_last, prev_l);
        end
        if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tmo("unexpected_beat");
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e[7:0]);
            chk("out_last", out_last, e[8]);
          end
        end
        if (len_err) lerr_cnt++;
        stall_prev = out_valid && !out_ready;
        prev_d = out_data;
        prev_l = out_last;
      end
    end
  end

  task automatic load_key(input logic [127:0] k, input logic b);
    int n = 0;
    logic acc;
    key_valid = 1'b1; key_in = k; bypass = b;
    do begin
      @(negedge clk); acc = key_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 100);
    if (!acc) tmo("key_load");
    key_valid = 1'b0; key_in = ~k; bypass = ~b;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n = 0;
    logic acc;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 100);
    if (!acc) tmo("beat_accept");
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h5a;
  endtask

  task automatic run_block(input logic [127:0] k, input logic [127:0] st,
                           input logic [127:0] ex, input logic b, input int last_at,
                           input int nbeats);
    load_key(k, b);
    for (int i = 0; i < nbeats; i++) begin
      sb.push_back({(i == last_at), ex[127 - 8*i -: 8]});
      send_beat(st[127 - 8*i -: 8], (i == last_at));
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    int lerr0;
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lerr0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain block, then bypass block
    lerr0 = lerr_cnt;
    run_block(K1, ST, EX1, 1'b0, 15, 16);
    drain("s1_drain");
    chk("s1_len_err", lerr_cnt - lerr0, 0);
    chk("s1_idle_busy", busy, 1'b0);
    run_block(K1, ST, ST, 1'b1, 15, 16);
    drain("s2_drain");

    // Back-pressure pattern
    mode = 1;
    lerr0 = lerr_cnt;
    run_block(K1, ST, EX1, 1'b0, 15, 16);
    drain("s3_drain");
    chk("s3_len_err", lerr_cnt - lerr0, 0);
    mode = 0;
    @(posedge clk); #1;

    // Early in_last on beat 5, then a full block starting at slice 0
    lerr0 = lerr_cnt;
    run_block(K1, ST, EX1, 1'b0, 5, 6);
    chk("s4_key_ready", key_ready, 1'b1);
    drain("s4_drain");
    chk("s4_len_err", lerr_cnt - lerr0, 1);
    run_block(K1, ST, EX1, 1'b0, 15, 16);
    drain("s4_next_drain");

    // Clear after 7 beats; beat offered with clear is dropped
    lerr0 = lerr_cnt;
    run_block(K1, ST, EX1, 1'b0, 99, 7);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    chk("s5_in_ready_clear", in_ready, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("s5_key_ready", key_ready, 1'b1);
    drain("s5_partial_drain");
    chk("s5_busy", busy, 1'b0);
    run_block(KF, ST, EXF, 1'b0, 15, 16);
    drain("s5_drain");
    chk("s5_len_err", lerr_cnt - lerr0, 0);

    // Asynchronous reset mid-block drops the held beat
    mode = 2;
    @(posedge clk); #1;
    load_key(K1, 1'b0);
    send_beat(8'h33, 1'b0);
    chk("r_busy_before", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("r_out_valid", out_valid, 1'b0);
    chk("r_key_ready", key_ready, 1'b1);
    chk("r_busy", busy, 1'b0);
    #1 rst_n = 1'b1;
    mode = 0;
    @(posedge clk); #1;
    run_block(K1, ST, EX1, 1'b0, 15, 16);
    drain("r_after_drain");

    // 32-bit beats, combinational output
    d2_key_valid = 1'b1; d2_key_in = K1;
    @(posedge clk); #1;
    d2_key_valid = 1'b0; d2_key_in = KF;
    chk("w32_key_ready", d2_key_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [127:0] st_v, ex_v;
      st_v = ST; ex_v = EX1;
      d2_in_valid = 1'b1; d2_in_data = st_v[127 - 32*i -: 32]; d2_in_last = (i == 3);
      #1;
      chk("w32_out_valid", d2_out_valid, 1'b1);
      chk("w32_out_data", d2_out_data, ex_v[127 - 32*i -: 32]);
      chk("w32_out_last", d2_out_last, (i == 3));
      @(posedge clk); #1;
    end
    d2_in_valid = 1'b0; d2_in_last = 1'b0;
    chk("w32_done_key_ready", d2_key_ready, 1'b1);
    chk("w32_len_err", d2_len_err, 1'b0);
    #1;
    chk("w32_busy", d2_busy, 1'b0);

    // 128-bit single beat, registered output
    d3_key_valid = 1'b1; d3_key_in = K1;
    @(posedge clk); #1;
    d3_key_valid = 1'b0; d3_key_in = KF;
    d3_in_valid = 1'b1; d3_in_data = ST; d3_in_last = 1'b1;
    @(posedge clk); #1;
    d3_in_valid = 1'b0; d3_in_last = 1'b0;
    chk("w128_out_valid", d3_out_valid, 1'b1);
    chk("w128_out_data", d3_out_data, EX1);
    chk("w128_out_last", d3_out_last, 1'b1);
    chk("w128_key_ready", d3_key_ready, 1'b1);
    chk("w128_len_err", d3_len_err, 1'b0);
    @(posedge clk); #1;
    chk("w128_out_valid_after", d3_out_valid, 1'b0);
    chk("w128_busy", d3_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
